// File: rtl/pc_speaker_pcm.sv
`default_nettype none
// ============================================================================
// pc_speaker_pcm : 1-bit PC speaker stream -> 16-bit PCM at 48 kHz (16x oversampled)
// Optional DC blocker enabled by macro PC_SPEAKER_DC_FILTER_EN.
// Revision: 1.0
// ============================================================================
module pc_speaker_pcm (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] clock_rate,
    input  logic        speaker_in,
    input  logic [1:0]  volume,
    output logic [15:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun
);
    localparam logic [27:0] C_SUB_RATE = 28'd768000;

    logic [27:0]        rate_q;
    logic [27:0]        acc_q;
    logic [27:0]        acc_d;
    logic [28:0]        sum_w;
    logic               ce_sub_w;
    logic [3:0]         idx_q;
    logic [4:0]         ones_q;
    logic [4:0]         ones_total_w;
    logic               close_w;
    logic [15:0]        raw_w;
    logic signed [15:0] scaled_w;
    logic [15:0]        load_val_w;
    logic [15:0]        sample_q;
    logic               valid_q;
    logic               overrun_q;

    assign sum_w = {1'b0, acc_q} + {1'b0, C_SUB_RATE};

    always_comb begin
        acc_d    = acc_q;
        ce_sub_w = 1'b0;
        if (rate_q != 28'd0) begin
            if (sum_w >= {1'b0, rate_q}) begin
                acc_d    = acc_q + C_SUB_RATE - rate_q;
                ce_sub_w = 1'b1;
            end else begin
                acc_d = sum_w[27:0];
            end
        end
    end

    assign ones_total_w = ones_q + {4'd0, speaker_in};
    assign close_w      = ce_sub_w && (idx_q == 4'd15);

    // ones*4096 - 32768 modulo 2^16 is the count with its MSB inverted; 16 ones saturates.
    assign raw_w    = ones_total_w[4] ? 16'h7FFF : {~ones_total_w[3], ones_total_w[2:0], 12'h000};
    assign scaled_w = $signed(raw_w) >>> volume;

`ifdef PC_SPEAKER_DC_FILTER_EN
    logic signed [15:0] x_prev_q;
    logic signed [15:0] y_prev_q;
    logic signed [18:0] x_ext_w;
    logic signed [18:0] xp_ext_w;
    logic signed [18:0] yp_ext_w;
    logic signed [18:0] y_full_w;

    assign x_ext_w  = {{3{scaled_w[15]}}, scaled_w};
    assign xp_ext_w = {{3{x_prev_q[15]}}, x_prev_q};
    assign yp_ext_w = {{3{y_prev_q[15]}}, y_prev_q};
    assign y_full_w = x_ext_w - xp_ext_w + yp_ext_w - (yp_ext_w >>> 8);

    always_comb begin
        if (y_full_w > 19'sd32767) begin
            load_val_w = 16'h7FFF;
        end else if (y_full_w < -19'sd32768) begin
            load_val_w = 16'h8000;
        end else begin
            load_val_w = y_full_w[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_prev_q <= 16'sd0;
            y_prev_q <= 16'sd0;
        end else if (close_w) begin
            x_prev_q <= scaled_w;
            y_prev_q <= $signed(load_val_w);
        end
    end
`else
    assign load_val_w = scaled_w;
`endif

    always_ff @(posedge clk) begin
        rate_q <= clock_rate;
        if (reset) begin
            acc_q     <= 28'd0;
            idx_q     <= 4'd0;
            ones_q    <= 5'd0;
            sample_q  <= 16'h0000;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (ce_sub_w) begin
                idx_q  <= idx_q + 4'd1;
                ones_q <= close_w ? 5'd0 : ones_total_w;
            end
            // A load on a consuming cycle replaces the sample without flagging overrun.
            if (close_w) begin
                sample_q <= load_val_w;
                valid_q  <= 1'b1;
                if (valid_q && !sample_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_speaker_pcm.sv
`default_nettype none
// ============================================================================
// tb_pc_speaker_pcm : self-checking bench for pc_speaker_pcm against a window-level model
// Revision: 1.0
// ============================================================================
module tb_pc_speaker_pcm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] clock_rate = 28'd30000000;
    logic        speaker_in = 1'b0;
    logic [1:0]  volume = 2'd0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    bit rand_mode = 1'b0;
    bit alt_mode  = 1'b0;

    pc_speaker_pcm dut (
        .clk          (clk),
        .reset        (reset),
        .clock_rate   (clock_rate),
        .speaker_in   (speaker_in),
        .volume       (volume),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: sub-sample bits collected into 16-entry windows.
    longint      m_phase = 0;
    longint      m_rate = 0;
    bit          m_bits[$];
    bit          m_ce;
    bit          m_load;
    logic [15:0] m_sample = 16'h0000;
    bit          m_valid = 1'b0;
    bit          m_ovr = 1'b0;
    int          m_loads = 0;
    int          m_sub = 0;
    int          m_ones;
    int          m_val;
    int          m_xp = 0;
    int          m_yp = 0;

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int pcm_value(input int ones, input int vol);
        int raw;
        raw = ones * 4096 - 32768;
        if (raw > 32767) raw = 32767;
        return floor_div(raw, 1 << vol);
    endfunction

    always @(posedge clk) begin
        m_ce   = 1'b0;
        m_load = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_bits.delete();
            m_sample = 16'h0000;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_sub    = 0;
            m_xp     = 0;
            m_yp     = 0;
        end else begin
            if (m_rate != 0) begin
                m_phase = m_phase + 768000;
                if (m_phase >= m_rate) begin
                    m_phase = m_phase - m_rate;
                    m_ce    = 1'b1;
                end
            end
            if (m_ce) begin
                m_bits.push_back(speaker_in);
                m_sub++;
            end
            if (m_bits.size() == 16) begin
                m_ones = 0;
                foreach (m_bits[k]) m_ones += int'(m_bits[k]);
                m_bits.delete();
                m_val = pcm_value(m_ones, int'(volume));
`ifdef PC_SPEAKER_DC_FILTER_EN
                begin
                    int y;
                    y = m_val - m_xp + m_yp - floor_div(m_yp, 256);
                    if (y > 32767) y = 32767;
                    if (y < -32768) y = -32768;
                    m_xp  = m_val;
                    m_yp  = y;
                    m_val = y;
                end
`endif
                m_load = 1'b1;
            end
            if (m_load) begin
                if (m_valid && !sample_ready) m_ovr = 1'b1;
                m_sample = m_val[15:0];
                m_valid  = 1'b1;
                m_loads++;
            end else if (m_valid && sample_ready) begin
                m_valid = 1'b0;
            end
        end
        m_rate = longint'(clock_rate);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        chk("sample", {16'd0, sample}, {16'd0, m_sample});
        chk("valid", {31'd0, sample_valid}, {31'd0, m_valid});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (rand_mode) begin
            speaker_in   = 1'($urandom_range(0, 1));
            sample_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) volume = 2'($urandom_range(0, 3));
        end else if (alt_mode) begin
            speaker_in = m_sub[0];
        end
    endtask

    task automatic wait_pulse(input int bound, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (sample_valid !== 1'b1 && cyc < bound);
        chk("pulse_timeout", {31'd0, sample_valid}, 32'd1);
    endtask

    task automatic wait_loads(input int n, input int bound);
        int target;
        int c;
        target = m_loads + n;
        c = 0;
        while (m_loads < target && c < bound) begin
            tick();
            c++;
        end
        chk("load_timeout", {31'd0, (m_loads >= target)}, 32'd1);
    endtask

    initial begin
        int cyc;
        int cnt;
        repeat (3) tick();
        chk("rst_sample", {16'd0, sample}, 32'h0000);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;

        // Silence at full scale: one pulse per 625 clk carrying the most negative code.
        wait_pulse(1000, cyc);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(1000, cyc);
            chk("period", {31'd0, (cyc >= 624 && cyc <= 626)}, 32'd1);
`ifndef PC_SPEAKER_DC_FILTER_EN
            chk("silence", {16'd0, sample}, 32'h8000);
`endif
        end

        volume     = 2'd2;
        speaker_in = 1'b1;
        wait_pulse(1000, cyc);
        wait_pulse(1000, cyc);
`ifndef PC_SPEAKER_DC_FILTER_EN
        chk("full_vol2", {16'd0, sample}, 32'h1FFF);
`endif

        volume   = 2'd0;
        alt_mode = 1'b1;
        wait_pulse(1000, cyc);
        wait_pulse(1000, cyc);
`ifndef PC_SPEAKER_DC_FILTER_EN
        chk("half_vol0", {16'd0, sample}, 32'h0000);
`endif
        volume = 2'd3;
        wait_pulse(1000, cyc);
        wait_pulse(1000, cyc);
`ifndef PC_SPEAKER_DC_FILTER_EN
        chk("half_vol3", {16'd0, sample}, 32'h0000);
`endif
        alt_mode = 1'b0;

        // Random bits, back-pressure and volume changes, with a mid-window reset.
        rand_mode = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (i == 3100) reset = 1'b1;
            if (i == 3103) reset = 1'b0;
        end
        rand_mode = 1'b0;

        reset = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
        sample_ready = 1'b0;
        speaker_in   = 1'b1;
        volume       = 2'd0;
        wait_loads(1, 1000);
        chk("ovr_first", {16'd0, sample}, 32'h7FFF);
        chk("ovr_clear", {31'd0, overrun}, 32'd0);
        volume = 2'd1;
        wait_loads(1, 1000);
`ifndef PC_SPEAKER_DC_FILTER_EN
        chk("ovr_second", {16'd0, sample}, 32'h3FFF);
`endif
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_valid", {31'd0, sample_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("ovr_rst", {31'd0, overrun}, 32'd0);
        chk("ovr_rst_valid", {31'd0, sample_valid}, 32'd0);

        clock_rate = 28'd0;
        tick();
        tick();
        reset        = 1'b0;
        sample_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (sample_valid === 1'b1) cnt++;
        end
        chk("rate0_novalid", cnt, 32'd0);
        clock_rate = 28'd30000000;
        wait_pulse(1000, cyc);
        chk("rate0_latency", {31'd0, (cyc >= 615 && cyc <= 640)}, 32'd1);

`ifdef PC_SPEAKER_DC_FILTER_EN
        begin
            int prev;
            reset = 1'b1;
            tick();
            reset      = 1'b0;
            speaker_in = 1'b1;
            volume     = 2'd0;
            wait_pulse(1000, cyc);
            chk("filt_first", {16'd0, sample}, 32'h7FFF);
            prev = int'($signed(sample));
            for (int i = 0; i < 5; i++) begin
                wait_pulse(1000, cyc);
                chk("filt_decay", {31'd0, (int'($signed(sample)) < prev && int'($signed(sample)) > 0)}, 32'd1);
                prev = int'($signed(sample));
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
